// File: rtl/mvm_mac_ctrl_if.sv
// Handshake/bus bundle for mvm_mac_ctrl: input stream, memory strobes/addresses,
// mac control and result handshake. master = controller side, slave = environment side.
interface mvm_mac_ctrl_if #(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int AW_M = (M * N > 1) ? $clog2(M * N) : 1,
  parameter int AW_X = (N > 1) ? $clog2(N) : 1,
  parameter int RW   = (M > 1) ? $clog2(M) : 1
);
  logic            s_valid;
  logic            s_ready;
  logic            wr_en_m;
  logic            wr_en_x;
  logic [AW_M-1:0] addr_m;
  logic [AW_X-1:0] addr_x;
  logic            mac_valid;
  logic            mac_clear;
  logic            mac_valid_out;
  logic            o_valid;
  logic            o_ready;
  logic [RW-1:0]   o_row;

  modport master (
    input  s_valid, mac_valid_out, o_ready,
    output s_ready, wr_en_m, wr_en_x, addr_m, addr_x,
           mac_valid, mac_clear, o_valid, o_row
  );

  modport slave (
    output s_valid, mac_valid_out, o_ready,
    input  s_ready, wr_en_m, wr_en_x, addr_m, addr_x,
           mac_valid, mac_clear, o_valid, o_row
  );
endinterface

// File: rtl/mvm_mac_ctrl.sv
// Sequencing controller for a y = M*x matrix-vector product on one external MAC.
// Optional feature MATRIX_REUSE_EN: keep the matrix and reload only x after the last row.
module mvm_mac_ctrl #(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int AW_M = (M * N > 1) ? $clog2(M * N) : 1,
  parameter int AW_X = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  mvm_mac_ctrl_if.master  bus
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [AW_M-1:0] LAST_M   = AW_M'(M * N - 1);
  localparam logic [AW_X-1:0] LAST_X   = AW_X'(N - 1);
  localparam logic [RW-1:0]   LAST_ROW = RW'(M - 1);
  localparam logic [CW-1:0]   N_CNT    = CW'(N);
  localparam logic [CW-1:0]   PRE_CNT  = CW'(N - 1);

  typedef enum logic [2:0] {
    LOAD_M,
    LOAD_X,
    CLEAR,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  state_t          state;
  logic [AW_M-1:0] addr_m;
  logic [AW_X-1:0] addr_x;
  logic [RW-1:0]   row;
  logic [CW-1:0]   pulse_cnt;
  logic            mac_valid;
  logic            mac_clear;
  logic            o_valid;
  logic [RW-1:0]   o_row;

  logic            loading;
  logic            s_ready;
  logic            beat;
  logic            count_en;
  logic            drain_done;
  logic [AW_M-1:0] row_base;

  assign loading    = (state == LOAD_M) || (state == LOAD_X);
  assign s_ready    = loading && !reset;
  assign beat       = bus.s_valid && s_ready;
  assign count_en   = ((state == ISSUE) || (state == DRAIN)) && bus.mac_valid_out;
  assign drain_done = (pulse_cnt == N_CNT) || (count_en && (pulse_cnt == PRE_CNT));
  assign row_base   = AW_M'(int'(row) * N);

  // Pulses arriving outside ISSUE/DRAIN belong to nobody and are dropped;
  // the count restarts in CLEAR so each row sees exactly its own N results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_M;
      addr_m    <= '0;
      addr_x    <= '0;
      row       <= '0;
      pulse_cnt <= '0;
      mac_valid <= 1'b0;
      mac_clear <= 1'b0;
      o_valid   <= 1'b0;
      o_row     <= '0;
    end else begin
      mac_valid <= 1'b0;
      mac_clear <= 1'b0;
      if (count_en) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end

      case (state)
        LOAD_M: begin
          if (beat) begin
            if (addr_m == LAST_M) begin
              addr_m <= '0;
              addr_x <= '0;
              state  <= LOAD_X;
            end else begin
              addr_m <= addr_m + 1'b1;
            end
          end
        end

        LOAD_X: begin
          if (beat) begin
            if (addr_x == LAST_X) begin
              addr_x    <= '0;
              row       <= '0;
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end else begin
              addr_x <= addr_x + 1'b1;
            end
          end
        end

        CLEAR: begin
          pulse_cnt <= '0;
          addr_m    <= row_base;
          addr_x    <= '0;
          state     <= ISSUE;
        end

        // mac_valid trails each address by one cycle to match the memory read latency.
        ISSUE: begin
          mac_valid <= 1'b1;
          if (addr_x == LAST_X) begin
            state <= DRAIN;
          end else begin
            addr_m <= addr_m + 1'b1;
            addr_x <= addr_x + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_done) begin
            o_valid <= 1'b1;
            o_row   <= row;
            state   <= OUT;
          end
        end

        OUT: begin
          if (bus.o_ready) begin
            o_valid <= 1'b0;
            if (row == LAST_ROW) begin
              addr_m <= '0;
              addr_x <= '0;
              row    <= '0;
`ifdef MATRIX_REUSE_EN
              state  <= LOAD_X;
`else
              state  <= LOAD_M;
`endif
            end else begin
              row       <= row + 1'b1;
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end
          end
        end

        default: begin
          state <= LOAD_M;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.wr_en_m   = beat && (state == LOAD_M);
  assign bus.wr_en_x   = beat && (state == LOAD_X);
  assign bus.addr_m    = addr_m;
  assign bus.addr_x    = addr_x;
  assign bus.mac_valid = mac_valid;
  assign bus.mac_clear = mac_clear;
  assign bus.o_valid   = o_valid;
  assign bus.o_row     = o_row;

`ifndef SYNTHESIS
  a_wr_exclusive: assert property (@(posedge clk) !(bus.wr_en_m && bus.wr_en_x));

  a_no_issue_while_loading: assert property (
    @(posedge clk) disable iff (reset) mac_valid |-> !loading);

  a_out_stable: assert property (
    @(posedge clk) disable iff (reset)
    (o_valid && !bus.o_ready) |=> (o_valid && $stable(o_row)));
`endif

endmodule

// File: tb/tb_mvm_mac_ctrl.sv
// Self-checking bench for mvm_mac_ctrl with sync-read memories and a 4-cycle saturating mac.
// Expected results come from a plain matrix-vector product over the words the bench streamed.
module tb_mvm_mac_ctrl;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int RW = 2;
`ifdef MATRIX_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mvm_mac_ctrl_if #(.M(M), .N(N)) bus ();

  mvm_mac_ctrl #(.M(M), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int ref_m [M*N];
  int ref_x [N];

  logic signed [11:0] s_data;
  logic signed [11:0] mem_m [M*N];
  logic signed [11:0] mem_x [N];
  logic signed [11:0] rd_m;
  logic signed [11:0] rd_x;

  // Sync-read memories written from the stream.
  always @(posedge clk) begin
    if (bus.wr_en_m) mem_m[bus.addr_m] <= s_data;
    if (bus.wr_en_x) mem_x[bus.addr_x] <= s_data;
    rd_m <= mem_m[bus.addr_m];
    rd_x <= mem_x[bus.addr_x];
  end

  function automatic logic signed [23:0] sat_add(input logic signed [23:0] a,
                                                 input logic signed [23:0] b);
    logic signed [24:0] s;
    s = a + b;
    if (s > 25'sd8388607) return 24'sh7FFFFF;
    if (s < -25'sd8388608) return 24'sh800000;
    return s[23:0];
  endfunction

  logic [3:0]         vpipe;
  logic signed [23:0] ppipe [3];
  logic signed [23:0] f;

  // Four-cycle mac; mac_clear acts like reset on it.
  always @(posedge clk) begin
    if (reset || bus.mac_clear) begin
      vpipe <= '0;
      f     <= '0;
    end else begin
      vpipe    <= {vpipe[2:0], bus.mac_valid};
      ppipe[0] <= rd_m * rd_x;
      ppipe[1] <= ppipe[0];
      ppipe[2] <= ppipe[1];
      if (vpipe[2]) f <= sat_add(f, ppipe[2]);
    end
  end
  assign bus.mac_valid_out = vpipe[3];

  int wq [$];
  int clr_total = 0;
  int mv_total  = 0;

  always @(posedge clk) begin
    if (bus.wr_en_m) wq.push_back(int'(bus.addr_m));
    if (bus.wr_en_x) wq.push_back(100 + int'(bus.addr_x));
    if (bus.mac_clear) clr_total++;
    if (bus.mac_valid) mv_total++;
  end

  function automatic int ref_row(input int r);
    int sum = 0;
    for (int j = 0; j < N; j++) sum += ref_m[r*N + j] * ref_x[j];
    if (sum > 8388607) sum = 8388607;
    if (sum < -8388608) sum = -8388608;
    return sum;
  endfunction

  task automatic set_pattern(input int xdir);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) ref_m[i*N + j] = i + 1;
    for (int j = 0; j < N; j++) ref_x[j] = (xdir == 0) ? j + 1 : N - j;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b0;
    s_data = '0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.s_ready !== 1'b0 || bus.wr_en_m !== 1'b0 || bus.wr_en_x !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_stream: s_ready=%b wr_en_m=%b wr_en_x=%b required 000",
               bus.s_ready, bus.wr_en_m, bus.wr_en_x);
    end
    total++;
    if (bus.addr_m !== '0 || bus.addr_x !== '0 || bus.o_row !== '0) begin
      bad++;
      $display("[TB] FAIL reset_addr: addr_m=%0d addr_x=%0d o_row=%0d required 0",
               bus.addr_m, bus.addr_x, bus.o_row);
    end
    total++;
    if (bus.mac_valid !== 1'b0 || bus.mac_clear !== 1'b0 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mac: mac_valid=%b mac_clear=%b o_valid=%b required 000",
               bus.mac_valid, bus.mac_clear, bus.o_valid);
    end
    bus.s_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.s_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_sready: got %b required 1", bus.s_ready);
    end
    @(negedge clk);
    total++;
    if (bus.addr_m !== '0 || wq.size() != 0) begin
      bad++;
      $display("[TB] FAIL idle_no_change: addr_m=%0d writes=%0d required 0 0",
               bus.addr_m, wq.size());
    end
  endtask

  task automatic test_load(input bit with_matrix, input int max_gap);
    int start = wq.size();
    int n_words = with_matrix ? M*N + N : N;
    int guard;
    int w;
    int expv;
    int got_n;
    for (int i = 0; i < n_words; i++) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      if (with_matrix && i < M*N) w = ref_m[i];
      else w = ref_x[i - (with_matrix ? M*N : 0)];
      s_data = 12'(w);
      bus.s_valid = 1'b1;
      guard = 0;
      while (bus.s_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        total++;
        bad++;
        $display("[TB] FAIL load_stall: word %0d s_ready=%b required 1", i, bus.s_ready);
        bus.s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    total++;
    if (bus.s_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_sready_after: got %b required 0", bus.s_ready);
    end
    got_n = wq.size() - start;
    total++;
    if (got_n != n_words) begin
      bad++;
      $display("[TB] FAIL load_write_count: got %0d required %0d", got_n, n_words);
    end
    for (int i = 0; i < n_words && i < got_n; i++) begin
      expv = (with_matrix && i < M*N) ? i : 100 + i - (with_matrix ? M*N : 0);
      total++;
      if (wq[start + i] != expv) begin
        bad++;
        $display("[TB] FAIL load_write_seq: write %0d got code %0d required %0d",
                 i, wq[start + i], expv);
      end
    end
  endtask

  task automatic test_compute(input int rows, input int bp_row, input bit ready_early);
    int clr0 = clr_total;
    int mv0  = mv_total;
    int guard;
    int expv;
    for (int r = 0; r < rows; r++) begin
      bus.o_ready = ready_early;
      guard = 0;
      while (bus.o_valid !== 1'b1 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        total++;
        bad++;
        $display("[TB] FAIL result_timeout: row %0d o_valid=%b required 1", r, bus.o_valid);
        bus.o_ready = 1'b0;
        return;
      end
      expv = ref_row(r);
      total++;
      if (bus.o_row !== RW'(r)) begin
        bad++;
        $display("[TB] FAIL result_row: got %0d required %0d", bus.o_row, r);
      end
      total++;
      if (int'(f) != expv) begin
        bad++;
        $display("[TB] FAIL result_value: row %0d got %0d required %0d", r, int'(f), expv);
      end
      total++;
      if (clr_total - clr0 != 1 || mv_total - mv0 != N) begin
        bad++;
        $display("[TB] FAIL row_mac_counts: row %0d clears=%0d valids=%0d required 1 %0d",
                 r, clr_total - clr0, mv_total - mv0, N);
      end
      if (r == bp_row && !ready_early) begin
        repeat (5) begin
          @(negedge clk);
          total++;
          if (bus.o_valid !== 1'b1 || bus.o_row !== RW'(r) ||
              clr_total - clr0 != 1 || mv_total - mv0 != N) begin
            bad++;
            $display("[TB] FAIL backpressure_hold: o_valid=%b o_row=%0d clears=%0d valids=%0d required 1 %0d 1 %0d",
                     bus.o_valid, bus.o_row, clr_total - clr0, mv_total - mv0, r, N);
          end
        end
      end
      bus.o_ready = 1'b1;
      @(negedge clk);
      bus.o_ready = 1'b0;
      total++;
      if (bus.o_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL handshake_drop: o_valid=%b required 0", bus.o_valid);
      end
      clr0 = clr_total;
      mv0  = mv_total;
    end
    if (rows == M) begin
      total++;
      if (bus.s_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL after_last_row_sready: got %b required 1", bus.s_ready);
      end
    end
  endtask

  task automatic test_reuse();
    set_pattern(1);
    test_load(!REUSE, 1);
    test_compute(M, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_pattern(0);
    test_load(!REUSE, 1);
    test_compute(2, -1, 1'b0);
    total++;
    if (bus.mac_clear !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_clear_row2: mac_clear=%b required 1", bus.mac_clear);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.mac_valid !== 1'b1 || bus.addr_m !== 4'(2*N + 2)) begin
      bad++;
      $display("[TB] FAIL midreset_issue: mac_valid=%b addr_m=%0d required 1 %0d",
               bus.mac_valid, bus.addr_m, 2*N + 2);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mac_valid !== 1'b0 || bus.o_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: mac_valid=%b o_valid=%b s_ready=%b required 000",
               bus.mac_valid, bus.o_valid, bus.s_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.s_ready !== 1'b1 || bus.addr_m !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_release: s_ready=%b addr_m=%0d required 1 0",
               bus.s_ready, bus.addr_m);
    end
    test_load(1'b1, 2);
    test_compute(M, -1, 1'b0);
  endtask

  task automatic test_random(input int iter);
    for (int it = 0; it < iter; it++) begin
      if (!REUSE) begin
        for (int k = 0; k < M*N; k++) ref_m[k] = int'($urandom_range(0, 4000)) - 2000;
      end
      for (int j = 0; j < N; j++) ref_x[j] = int'($urandom_range(0, 4000)) - 2000;
      test_load(!REUSE, 3);
      test_compute(M, int'($urandom_range(0, M - 1)), it[0]);
    end
  endtask

  initial begin
    test_reset();
    set_pattern(0);
    test_load(1'b1, 2);
    test_compute(M, 1, 1'b0);
    test_reuse();
    test_reset_mid();
    test_random(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
